// File: rtl/arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Used by mem_port_arbiter and arb_pick; optional macro ARB_ROUND_ROBIN_EN affects only the top.
package arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam int REQ_IF  = 0;
   localparam int REQ_LS  = 1;
   localparam int REQ_EX  = 2;
   localparam int NUM_REQ = 3;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant picker: first eligible requester in the given priority order wins.
module arb_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] elig,
   input  logic [1:0]         ord0,
   input  logic [1:0]         ord1,
   input  logic [1:0]         ord2,
   output logic [NUM_REQ-1:0] gnt
);

   always_comb begin
      gnt = '0;
      if (elig[ord0])      gnt[ord0] = 1'b1;
      else if (elig[ord1]) gnt[ord1] = 1'b1;
      else if (elig[ord2]) gnt[ord2] = 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the shared 16-bit memory port with locked sequences and starvation promotion.
// Define ARB_ROUND_ROBIN_EN for round-robin ordering in the ARB state (default: fixed 1 > 0 > 2).
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_WAIT = 8,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req,
   input  logic [2:0]  lock,
   input  logic [2:0]  we,
   input  logic [2:0]  byte_half,
   input  logic [47:0] addr,
   input  logic [47:0] wdata,
   output logic [2:0]  gnt,
   output logic [2:0]  rvalid,
   output logic [15:0] rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_in,
   output logic        mem_we,
   output logic        mem_byte_half,
   input  logic [15:0] mem_out
);

   state_e             state_q, state_d;
   logic [1:0]         owner_q, owner_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [2:0]         rvalid_q, rvalid_d;
   logic [15:0]        rdata_q, rdata_d;
   logic [2:0]         gnt_o, pick_gnt;
   logic [1:0]         ord0, ord1, ord2;
   logic               promote;

   assign promote = (wait_cnt_q == CNT_W'(MAX_WAIT));

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] b0, b1, b2;

   always_comb begin
      b0 = ptr_q;
      b1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
      b2 = (b1 == 2'd2) ? 2'd0 : b1 + 2'd1;
      ord0 = b0;
      ord1 = b1;
      ord2 = b2;
      // Promotion puts requester 2 first, the others keep their pointer order.
      if (promote) begin
         ord0 = 2'd2;
         if (b0 == 2'd2) begin
            ord1 = b1;
            ord2 = b2;
         end else if (b1 == 2'd2) begin
            ord1 = b0;
            ord2 = b2;
         end else begin
            ord1 = b0;
            ord2 = b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ARB) begin
         if (gnt_o[0])      ptr_d = 2'd1;
         else if (gnt_o[1]) ptr_d = 2'd2;
         else if (gnt_o[2]) ptr_d = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= 2'd0;
      else        ptr_q <= ptr_d;
   end
`else
   always_comb begin
      ord0 = promote ? 2'd2 : 2'd1;
      ord1 = promote ? 2'd1 : 2'd0;
      ord2 = promote ? 2'd0 : 2'd2;
   end
`endif

   arb_pick u_pick (
      .elig (req),
      .ord0 (ord0),
      .ord1 (ord1),
      .ord2 (ord2),
      .gnt  (pick_gnt)
   );

   always_comb begin
      gnt_o   = '0;
      state_d = state_q;
      owner_d = owner_q;
      if (state_q == ARB) begin
         gnt_o = pick_gnt;
         for (int i = 1; i < NUM_REQ; i++) begin
            if (pick_gnt[i] && lock[i]) begin
               state_d = HOLD;
               owner_d = 2'(i);
            end
         end
      end else begin
         if (req[owner_q]) gnt_o[owner_q] = 1'b1;
         if (!(req[owner_q] && lock[owner_q])) state_d = ARB;
      end
      if (!rst_n) gnt_o = '0;
   end

   assign gnt = gnt_o;

   always_comb begin
      mem_addr      = '0;
      mem_in        = '0;
      mem_we        = 1'b0;
      mem_byte_half = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_o[i]) begin
            mem_addr      = addr[16*i +: 16];
            mem_in        = wdata[16*i +: 16];
            mem_we        = we[i];
            mem_byte_half = byte_half[i];
         end
      end
   end

   always_comb begin
      rvalid_d   = gnt_o & ~we;
      rdata_d    = (|rvalid_d) ? mem_out : rdata_q;
      wait_cnt_d = wait_cnt_q;
      if (!req[REQ_EX] || gnt_o[REQ_EX])
         wait_cnt_d = '0;
      else if (wait_cnt_q < CNT_W'(MAX_WAIT))
         wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ARB;
         owner_q    <= 2'd0;
         wait_cnt_q <= '0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wait_cnt_q <= wait_cnt_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter; round-robin scenario runs only with ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req, lock, we, byte_half;
   logic [47:0] addr, wdata;
   logic [2:0]  gnt, rvalid;
   logic [15:0] rdata, mem_addr, mem_in, mem_out;
   logic        mem_we, mem_byte_half;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Memory model: one fixed word, otherwise address xor a constant.
   assign mem_out = (mem_addr == 16'h0040) ? 16'h1234 : (mem_addr ^ 16'hA5A5);

   mem_port_arbiter #(.MAX_WAIT(8), .CNT_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .lock          (lock),
      .we            (we),
      .byte_half     (byte_half),
      .addr          (addr),
      .wdata         (wdata),
      .gnt           (gnt),
      .rvalid        (rvalid),
      .rdata         (rdata),
      .mem_addr      (mem_addr),
      .mem_in        (mem_in),
      .mem_we        (mem_we),
      .mem_byte_half (mem_byte_half),
      .mem_out       (mem_out)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req = 3'b000; lock = 3'b000; we = 3'b000; byte_half = 3'b000;
      cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 3'b111; lock = 3'b000; we = 3'b000; byte_half = 3'b000;
      addr = {16'h3333, 16'h2222, 16'h1111}; wdata = '0;
      cyc(); cyc();
      #1;
      n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
      n_vec++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
      n_vec++; if (mem_byte_half !== 1'b1) begin n_err++; $display("FAIL reset_byte_half got=%b exp=1", mem_byte_half); end
      n_vec++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
      n_vec++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
      rst_n = 1'b1;
      idle();
   endtask

   task automatic test_fetch_read();
      req = 3'b001; we = 3'b000; byte_half = 3'b000; addr = {16'h3333, 16'h2222, 16'h0040};
      #1;
      n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL fetch_gnt got=%b exp=001", gnt); end
      n_vec++; if (mem_addr !== 16'h0040) begin n_err++; $display("FAIL fetch_mem_addr got=%h exp=0040", mem_addr); end
      n_vec++; if (mem_byte_half !== 1'b0) begin n_err++; $display("FAIL fetch_byte_half got=%b exp=0", mem_byte_half); end
      cyc();
      req = 3'b000;
      #1;
      n_vec++; if (rvalid !== 3'b001) begin n_err++; $display("FAIL fetch_rvalid got=%b exp=001", rvalid); end
      n_vec++; if (rdata !== 16'h1234) begin n_err++; $display("FAIL fetch_rdata got=%h exp=1234", rdata); end
      n_vec++; if (mem_byte_half !== 1'b1) begin n_err++; $display("FAIL fetch_idle_byte_half got=%b exp=1", mem_byte_half); end
      cyc();
      n_vec++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL fetch_rvalid_drop got=%b exp=000", rvalid); end
      n_vec++; if (rdata !== 16'h1234) begin n_err++; $display("FAIL fetch_rdata_hold got=%h exp=1234", rdata); end
   endtask

   task automatic test_contention();
      req = 3'b111; we = 3'b000; addr = {16'h0300, 16'h0200, 16'h0010};
      for (int k = 0; k < 3; k++) begin
         #1;
         n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL contention_gnt%0d got=%b exp=010", k, gnt); end
         n_vec++; if (mem_addr !== 16'h0200) begin n_err++; $display("FAIL contention_addr%0d got=%h exp=0200", k, mem_addr); end
         cyc();
      end
      req = 3'b101;
      #1;
      n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL contention_fetch got=%b exp=001", gnt); end
      cyc();
      n_vec++; if (rdata !== 16'hA5B5) begin n_err++; $display("FAIL contention_rdata got=%h exp=a5b5", rdata); end
      idle();
   endtask

   task automatic test_lock();
      req = 3'b011; lock = 3'b010; we = 3'b000; addr = {16'h0000, 16'h0100, 16'h0020};
      wdata = {16'h0000, 16'hBEEF, 16'h0000};
      #1;
      n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL lock_gnt1 got=%b exp=010", gnt); end
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL lock_we1 got=%b exp=0", mem_we); end
      cyc();
      n_vec++; if (rdata !== 16'hA4A5) begin n_err++; $display("FAIL lock_rdata got=%h exp=a4a5", rdata); end
      we = 3'b010; lock = 3'b000;
      #1;
      n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL lock_gnt2 got=%b exp=010", gnt); end
      n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL lock_we2 got=%b exp=1", mem_we); end
      n_vec++; if (mem_in !== 16'hBEEF) begin n_err++; $display("FAIL lock_mem_in got=%h exp=beef", mem_in); end
      cyc();
      n_vec++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL lock_write_rvalid got=%b exp=000", rvalid); end
      req = 3'b001; we = 3'b000;
      #1;
      n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL lock_gnt3 got=%b exp=001", gnt); end
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL lock_we3 got=%b exp=0", mem_we); end
      cyc();
      idle();
   endtask

   task automatic test_hold_owner_drop();
      req = 3'b011; lock = 3'b010; we = 3'b000;
      #1;
      n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL hold_enter got=%b exp=010", gnt); end
      cyc();
      req = 3'b001; lock = 3'b000;
      #1;
      n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL hold_drop got=%b exp=000", gnt); end
      cyc();
      #1;
      n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL hold_release got=%b exp=001", gnt); end
      cyc();
      idle();
   endtask

   task automatic test_starvation();
      req = 3'b110; lock = 3'b000; we = 3'b000;
      for (int k = 1; k <= 10; k++) begin
         #1;
         if (k == 9) begin
            n_vec++; if (gnt !== 3'b100) begin n_err++; $display("FAIL starve_c%0d got=%b exp=100", k, gnt); end
         end else begin
            n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL starve_c%0d got=%b exp=010", k, gnt); end
         end
         cyc();
      end
      idle();
   endtask

   task automatic test_promote_vs_hold();
      req = 3'b110; lock = 3'b010; we = 3'b000;
      for (int k = 1; k <= 10; k++) begin
         #1;
         n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL promhold_c%0d got=%b exp=010", k, gnt); end
         cyc();
      end
      lock = 3'b000;
      #1;
      n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL promhold_final got=%b exp=010", gnt); end
      cyc();
      #1;
      n_vec++; if (gnt !== 3'b100) begin n_err++; $display("FAIL promhold_ext got=%b exp=100", gnt); end
      cyc();
      #1;
      n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL promhold_after got=%b exp=010", gnt); end
      cyc();
      idle();
   endtask

   task automatic test_reset_mid_read();
      req = 3'b010; lock = 3'b010; we = 3'b000; addr = {16'h0000, 16'h0100, 16'h0040};
      #1;
      n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL rstmid_gnt got=%b exp=010", gnt); end
      cyc();
      n_vec++; if (rvalid !== 3'b010) begin n_err++; $display("FAIL rstmid_rvalid_pre got=%b exp=010", rvalid); end
      rst_n = 1'b0; req = 3'b001; lock = 3'b000;
      #1;
      n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rstmid_gnt_rst got=%b exp=000", gnt); end
      n_vec++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL rstmid_mem_addr got=%h exp=0000", mem_addr); end
      cyc();
      n_vec++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL rstmid_rvalid got=%b exp=000", rvalid); end
      n_vec++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL rstmid_rdata got=%h exp=0000", rdata); end
      rst_n = 1'b1;
      #1;
      n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL rstmid_arb got=%b exp=001", gnt); end
      cyc();
      idle();
   endtask

`ifdef ARB_ROUND_ROBIN_EN
   task automatic test_round_robin();
      logic [2:0] exp_seq [4];
      exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
      req = 3'b111; lock = 3'b000; we = 3'b000;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_vec++; if (gnt !== exp_seq[k]) begin n_err++; $display("FAIL rr_c%0d got=%b exp=%b", k, gnt, exp_seq[k]); end
         cyc();
      end
      idle();
   endtask
`endif

   initial begin
      test_reset();
`ifdef ARB_ROUND_ROBIN_EN
      test_round_robin();
      test_fetch_read();
      test_reset_mid_read();
`else
      test_fetch_read();
      test_contention();
      test_lock();
      test_hold_owner_drop();
      test_starvation();
      test_promote_vs_hold();
      test_reset_mid_read();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
